// File: rtl/csr_file_irq_pkg.sv
// Shared CSR definitions for the machine-mode CSR file:
//   - CSR addresses and the per-CSR writable-bit masks
//   - CSR operation and mtvec mode encodings
//   - machine interrupt cause codes and mstatus bit positions
//   - csr_apply(): computes the RW/RS/RC result before masking
package riscv_defines;

  localparam logic [11:0] CSR_ADDR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_ADDR_MIE           = 12'h304;
  localparam logic [11:0] CSR_ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_ADDR_MIP           = 12'h344;
  localparam logic [11:0] CSR_ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_ADDR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_ADDR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_ADDR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_ADDR_MHARTID       = 12'hF14;

  // Writable bits. MPP stays at M (only machine mode exists); mip bits follow the lines.
  localparam logic [31:0] CSR_MASK_MSTATUS       = 32'h0000_0088;
  localparam logic [31:0] CSR_MASK_MIE           = 32'h0000_0888;
  localparam logic [31:0] CSR_MASK_MTVEC         = 32'hFFFF_FFFF;
  localparam logic [31:0] CSR_MASK_MCOUNTINHIBIT = 32'h0000_0005;
  localparam logic [31:0] CSR_MASK_MSCRATCH      = 32'hFFFF_FFFF;
  localparam logic [31:0] CSR_MASK_MEPC          = 32'hFFFF_FFFC;
  localparam logic [31:0] CSR_MASK_MCAUSE        = 32'hFFFF_FFFF;
  localparam logic [31:0] CSR_MASK_MTVAL         = 32'hFFFF_FFFF;
  localparam logic [31:0] CSR_MASK_MIP           = 32'h0000_0000;
  localparam logic [31:0] CSR_MASK_MCYCLE        = 32'hFFFF_FFFF;
  localparam logic [31:0] CSR_MASK_MCYCLEH       = 32'hFFFF_FFFF;
  localparam logic [31:0] CSR_MASK_MINSTRET      = 32'hFFFF_FFFF;
  localparam logic [31:0] CSR_MASK_MINSTRETH     = 32'hFFFF_FFFF;
  localparam logic [31:0] CSR_MASK_RO            = 32'h0000_0000;

  localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
  localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MCI_CY       = 0;
  localparam int MCI_IR       = 2;

  typedef enum logic [1:0] {
    CSR_OP_RD = 2'b00,
    CSR_OP_RW = 2'b01,
    CSR_OP_RS = 2'b10,
    CSR_OP_RC = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_RW: return wdata;
      CSR_OP_RS: return old | wdata;
      CSR_OP_RC: return old & ~wdata;
      default:   return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable 32-bit halves.
//   clk, rst         clock, synchronous active-high reset
//   en_i             counting allowed (not inhibited)
//   inc_i            event this cycle
//   wr_lo_i/wr_hi_i  replace low/high half with wdata_i; blocks this cycle's increment
//   value_o          current count
// EN=0 ties the counter to zero.
module csr_counter64 #(
  parameter bit EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);
  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end else if (en_i && inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
    if (!EN) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;
endmodule

// File: rtl/csr_file_irq.sv
// Machine-mode CSR file with 64-bit cycle/instret counters, live interrupt pending,
// prioritised interrupt request and vectored trap entry.
//   clk, rst                       clock, synchronous active-high reset
//   csr_valid/addr/op/wen/wdata    CSR access from execute
//   csr_rdata, csr_illegal         old value (0 when idle/illegal), illegal-access flag
//   trap_enter/return/cause/pc/tval trap and mret events
//   instret_inc                    retirement strobe for minstret
//   irq_ext/irq_timer/irq_soft     synchronised level interrupt lines
//   irq_req, irq_cause             pending enabled interrupt and its mcause value
//   trap_vector, mepc_o            trap target for trap_cause, current mepc
module csr_file_irq
  import riscv_defines::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter bit          COUNTERS_EN = 1'b1,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic        csr_wen,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_enter,
  input  logic        trap_return,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        instret_inc,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_o
);
  localparam logic [31:0] MTVEC_RST = VECTORED_EN ? MTVEC_RESET : {MTVEC_RESET[31:2], 2'b00};

  logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d, mip_q, mip_d;
  logic [31:0] mcinh_q, mcinh_d;
  logic [63:0] mcycle, minstret;

  logic [31:0] rd_raw, wmask, wr_eff, mtvec_wr;
  logic        known, csr_we;

  // Read mux and write mask share the address decode.
  always_comb begin
    rd_raw = '0;
    wmask  = CSR_MASK_RO;
    known  = 1'b1;
    case (csr_addr)
      CSR_ADDR_MSTATUS:       begin rd_raw = mstatus_q;       wmask = CSR_MASK_MSTATUS;       end
      CSR_ADDR_MIE:           begin rd_raw = mie_q;           wmask = CSR_MASK_MIE;           end
      CSR_ADDR_MTVEC:         begin rd_raw = mtvec_q;         wmask = CSR_MASK_MTVEC;         end
      CSR_ADDR_MCOUNTINHIBIT: begin rd_raw = mcinh_q;         wmask = CSR_MASK_MCOUNTINHIBIT; end
      CSR_ADDR_MSCRATCH:      begin rd_raw = mscratch_q;      wmask = CSR_MASK_MSCRATCH;      end
      CSR_ADDR_MEPC:          begin rd_raw = mepc_q;          wmask = CSR_MASK_MEPC;          end
      CSR_ADDR_MCAUSE:        begin rd_raw = mcause_q;        wmask = CSR_MASK_MCAUSE;        end
      CSR_ADDR_MTVAL:         begin rd_raw = mtval_q;         wmask = CSR_MASK_MTVAL;         end
      CSR_ADDR_MIP:           begin rd_raw = mip_q;           wmask = CSR_MASK_MIP;           end
      CSR_ADDR_MCYCLE:        begin rd_raw = mcycle[31:0];    wmask = CSR_MASK_MCYCLE;        end
      CSR_ADDR_MCYCLEH:       begin rd_raw = mcycle[63:32];   wmask = CSR_MASK_MCYCLEH;       end
      CSR_ADDR_MINSTRET:      begin rd_raw = minstret[31:0];  wmask = CSR_MASK_MINSTRET;      end
      CSR_ADDR_MINSTRETH:     begin rd_raw = minstret[63:32]; wmask = CSR_MASK_MINSTRETH;     end
      CSR_ADDR_MVENDORID, CSR_ADDR_MARCHID, CSR_ADDR_MIMPID: rd_raw = '0;
      CSR_ADDR_MHARTID:       rd_raw = HART_ID;
      default:                known = 1'b0;
    endcase
  end

  // addr[11:10]==2'b11 is the read-only CSR space.
  assign csr_illegal = csr_valid && (!known || (csr_wen && csr_addr[11:10] == 2'b11));
  assign csr_rdata   = (csr_valid && !csr_illegal) ? rd_raw : 32'h0;

  assign wr_eff = (rd_raw & ~wmask) | (csr_apply(csr_op_e'(csr_op), rd_raw, csr_wdata) & wmask);
  assign csr_we = csr_valid && csr_wen && !csr_illegal && (csr_op != CSR_OP_RD)
                  && !trap_enter && !trap_return;

  // mtvec WARL: reserved or disabled modes fall back to direct; base kept 16-byte aligned.
  always_comb begin
    mtvec_wr = {wr_eff[31:4], 4'b0000};
    if (VECTORED_EN && wr_eff[1:0] == MTVEC_VECTORED) mtvec_wr[1:0] = MTVEC_VECTORED;
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcinh_d    = mcinh_q;
    mip_d      = '0;
    mip_d[11]  = irq_ext;
    mip_d[7]   = irq_timer;
    mip_d[3]   = irq_soft;
    if (trap_enter) begin
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]  = 1'b0;
      mepc_d   = {trap_pc[31:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
    end else if (trap_return) begin
      mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_ADDR_MSTATUS:       mstatus_d  = wr_eff;
        CSR_ADDR_MIE:           mie_d      = wr_eff;
        CSR_ADDR_MTVEC:         mtvec_d    = mtvec_wr;
        CSR_ADDR_MCOUNTINHIBIT: mcinh_d    = wr_eff;
        CSR_ADDR_MSCRATCH:      mscratch_d = wr_eff;
        CSR_ADDR_MEPC:          mepc_d     = wr_eff;
        CSR_ADDR_MCAUSE:        mcause_d   = wr_eff;
        CSR_ADDR_MTVAL:         mtval_d    = wr_eff;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= 32'h0000_1800;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      mcinh_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= mip_d;
      mcinh_q    <= mcinh_d;
    end
  end

  csr_counter64 #(.EN(COUNTERS_EN)) u_mcycle (
    .clk(clk), .rst(rst), .en_i(!mcinh_q[MCI_CY]), .inc_i(1'b1),
    .wr_lo_i(csr_we && csr_addr == CSR_ADDR_MCYCLE),
    .wr_hi_i(csr_we && csr_addr == CSR_ADDR_MCYCLEH),
    .wdata_i(wr_eff), .value_o(mcycle)
  );

  csr_counter64 #(.EN(COUNTERS_EN)) u_minstret (
    .clk(clk), .rst(rst), .en_i(!mcinh_q[MCI_IR]), .inc_i(instret_inc),
    .wr_lo_i(csr_we && csr_addr == CSR_ADDR_MINSTRET),
    .wr_hi_i(csr_we && csr_addr == CSR_ADDR_MINSTRETH),
    .wdata_i(wr_eff), .value_o(minstret)
  );

  // Interrupts: MEI > MSI > MTI among pending-and-enabled sources.
  logic [31:0] pend;
  assign pend    = mip_q & mie_q;
  assign irq_req = mstatus_q[MSTATUS_MIE] && (|pend);

  always_comb begin
    irq_cause = '0;
    if (irq_req) begin
      if (pend[11])     irq_cause = {1'b1, 26'b0, IRQ_CODE_MEI};
      else if (pend[3]) irq_cause = {1'b1, 26'b0, IRQ_CODE_MSI};
      else              irq_cause = {1'b1, 26'b0, IRQ_CODE_MTI};
    end
  end

  logic [31:0] tv_base;
  assign tv_base     = {mtvec_q[31:2], 2'b00};
  assign trap_vector = (mtvec_q[1:0] == MTVEC_VECTORED && trap_cause[31])
                       ? tv_base + {25'b0, trap_cause[4:0], 2'b00} : tv_base;
  assign mepc_o      = mepc_q;
endmodule

// File: tb/tb_csr_file_irq.sv
module tb_csr_file_irq;
  localparam logic [1:0] RD = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305,
    A_MCINH = 12'h320, A_MSCRATCH = 12'h340, A_MEPC = 12'h341, A_MCAUSE = 12'h342,
    A_MTVAL = 12'h343, A_MIP = 12'h344, A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02,
    A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82, A_MHARTID = 12'hF14, A_MVENDORID = 12'hF11;

  logic clk = 1'b0, rst = 1'b1;
  logic csr_valid = 0, csr_wen = 0, csr_illegal;
  logic [11:0] csr_addr = '0;
  logic [1:0] csr_op = '0;
  logic [31:0] csr_wdata = '0, csr_rdata;
  logic trap_enter = 0, trap_return = 0, instret_inc = 0;
  logic [31:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
  logic irq_ext = 0, irq_timer = 0, irq_soft = 0, irq_req;
  logic [31:0] irq_cause, trap_vector, mepc_o;

  int n_chk = 0, n_pass = 0;
  logic [31:0] rd;
  logic ill;

  csr_file_irq #(.HART_ID(32'h5), .MTVEC_RESET(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_enter(trap_enter), .trap_return(trap_return), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .instret_inc(instret_inc),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft), .irq_req(irq_req),
    .irq_cause(irq_cause), .trap_vector(trap_vector), .mepc_o(mepc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // One CSR access cycle; called at posedge+1, samples combinational outputs at posedge+2.
  task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic we,
                     input logic [31:0] wd, output logic [31:0] r, output logic il);
    csr_valid = 1; csr_op = op; csr_addr = a; csr_wen = we; csr_wdata = wd;
    #1; r = csr_rdata; il = csr_illegal;
    @(posedge clk); #1;
    csr_valid = 0; csr_wen = 0; csr_op = RD;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // 1 reset
    repeat (3) step();
    chk("rst_irq_req", irq_req, 0);
    chk("rst_rdata_idle", csr_rdata, 0);
    rst = 0;
    acc(RD, A_MCYCLE, 0, 0, rd, ill);     chk("mcycle_0", rd, 0);
    repeat (4) step();
    acc(RD, A_MCYCLE, 0, 0, rd, ill);     chk("mcycle_5", rd, 5);
    acc(RD, A_MSTATUS, 0, 0, rd, ill);    chk("rst_mstatus", rd, 32'h1800);
    acc(RD, A_MTVEC, 0, 0, rd, ill);      chk("rst_mtvec", rd, 32'h100);
    acc(RD, A_MHARTID, 0, 0, rd, ill);    chk("rst_mhartid", rd, 5); chk("mhartid_rd_legal", ill, 0);
    acc(RD, A_MIE, 0, 0, rd, ill);        chk("rst_mie", rd, 0);

    // 2 interrupts
    acc(RS, A_MIE, 1, 32'h888, rd, ill);
    acc(RS, A_MSTATUS, 1, 32'h8, rd, ill);
    acc(RD, A_MSTATUS, 0, 0, rd, ill);    chk("mstatus_mie_set", rd, 32'h1808);
    irq_timer = 1; irq_ext = 1;
    #1 chk("irq_latency", irq_req, 0);
    step();
    chk("irq_req", irq_req, 1);           chk("irq_cause_mei", irq_cause, 32'h8000000B);
    irq_ext = 0; step();
    chk("irq_cause_mti", irq_cause, 32'h80000007);
    irq_soft = 1; step();
    chk("irq_cause_msi", irq_cause, 32'h80000003);
    acc(RD, A_MIP, 0, 0, rd, ill);        chk("mip_read", rd, 32'h88);
    irq_soft = 0; irq_timer = 0; step();
    chk("irq_req_off", irq_req, 0);       chk("irq_cause_off", irq_cause, 0);
    acc(RW, A_MIE, 1, 32'hFFFF_FFFF, rd, ill);
    acc(RD, A_MIE, 0, 0, rd, ill);        chk("mie_mask", rd, 32'h888);

    // 3 vectored trap
    acc(RW, A_MTVEC, 1, 32'h1003, rd, ill);
    acc(RD, A_MTVEC, 0, 0, rd, ill);      chk("mtvec_warl_mode3", rd, 32'h1000);
    acc(RW, A_MTVEC, 1, 32'h1001, rd, ill);
    acc(RD, A_MTVEC, 0, 0, rd, ill);      chk("mtvec_vectored", rd, 32'h1001);
    trap_cause = 32'h2; #1;
    chk("tvec_exception", trap_vector, 32'h1000);
    trap_cause = 32'h80000007; trap_pc = 32'h203; trap_tval = 32'hBAD; #1;
    chk("tvec_irq", trap_vector, 32'h101C);
    trap_enter = 1; step(); trap_enter = 0;
    chk("trap_mepc", mepc_o, 32'h200);
    acc(RD, A_MSTATUS, 0, 0, rd, ill);    chk("trap_mstatus", rd, 32'h1880);
    acc(RD, A_MCAUSE, 0, 0, rd, ill);     chk("trap_mcause", rd, 32'h80000007);
    acc(RD, A_MTVAL, 0, 0, rd, ill);      chk("trap_mtval", rd, 32'hBAD);
    irq_ext = 1; step();
    chk("irq_masked_mie0", irq_req, 0);
    irq_ext = 0; step();

    // 4 trap priority vs CSR writes, mret
    trap_return = 1; step(); trap_return = 0;
    acc(RD, A_MSTATUS, 0, 0, rd, ill);    chk("mret_mstatus", rd, 32'h1888);
    acc(RW, A_MSCRATCH, 1, 32'h1234, rd, ill);
    trap_enter = 1; trap_cause = 32'h2; trap_pc = 32'h400;
    acc(RW, A_MSCRATCH, 1, 32'hDEAD, rd, ill);
    trap_enter = 0;
    acc(RD, A_MSCRATCH, 0, 0, rd, ill);   chk("trap_drops_write", rd, 32'h1234);
    acc(RD, A_MSTATUS, 0, 0, rd, ill);    chk("trap2_mstatus", rd, 32'h1880);
    trap_enter = 1; trap_return = 1; trap_pc = 32'h507; step();
    trap_enter = 0; trap_return = 0;
    chk("enter_wins_mepc", mepc_o, 32'h504);
    acc(RD, A_MSTATUS, 0, 0, rd, ill);    chk("enter_wins_mstatus", rd, 32'h1800);
    trap_return = 1;
    acc(RW, A_MSCRATCH, 1, 32'h77, rd, ill);
    trap_return = 0;
    acc(RD, A_MSCRATCH, 0, 0, rd, ill);   chk("mret_drops_write", rd, 32'h1234);
    acc(RD, A_MSTATUS, 0, 0, rd, ill);    chk("mret2_mstatus", rd, 32'h1880);

    // 5 counters
    acc(RW, A_MCYCLE, 1, 32'hFFFF_FFFF, rd, ill);
    acc(RW, A_MCYCLEH, 1, 32'h0, rd, ill);
    acc(RD, A_MCYCLE, 0, 0, rd, ill);     chk("mcycle_written", rd, 32'hFFFF_FFFF);
    acc(RD, A_MCYCLE, 0, 0, rd, ill);     chk("mcycle_carry_lo", rd, 0);
    acc(RD, A_MCYCLEH, 0, 0, rd, ill);    chk("mcycle_carry_hi", rd, 1);
    acc(RW, A_MCYCLE, 1, 32'hFFFF_FFFF, rd, ill);
    acc(RW, A_MCYCLEH, 1, 32'hFFFF_FFFF, rd, ill);
    acc(RD, A_MCYCLEH, 0, 0, rd, ill);    chk("mcycle_max_hi", rd, 32'hFFFF_FFFF);
    acc(RD, A_MCYCLE, 0, 0, rd, ill);     chk("mcycle_wrap_lo", rd, 0);
    acc(RD, A_MCYCLEH, 0, 0, rd, ill);    chk("mcycle_wrap_hi", rd, 0);
    instret_inc = 1;
    acc(RD, A_MINSTRET, 0, 0, rd, ill);   chk("minstret_0", rd, 0);
    acc(RD, A_MINSTRET, 0, 0, rd, ill);   chk("minstret_1", rd, 1);
    acc(RS, A_MCINH, 1, 32'h4, rd, ill);
    acc(RD, A_MINSTRET, 0, 0, rd, ill);   chk("minstret_inh_a", rd, 3);
    acc(RD, A_MINSTRET, 0, 0, rd, ill);   chk("minstret_inh_b", rd, 3);
    acc(RW, A_MINSTRET, 1, 32'h10, rd, ill);
    acc(RD, A_MINSTRET, 0, 0, rd, ill);   chk("minstret_wr_inh", rd, 32'h10);
    acc(RD, A_MINSTRETH, 0, 0, rd, ill);  chk("minstreth", rd, 0);
    acc(RD, A_MCINH, 0, 0, rd, ill);      chk("mcountinhibit", rd, 32'h4);

    // 6 illegal accesses
    acc(RW, A_MHARTID, 1, 32'h99, rd, ill);
    chk("ro_write_illegal", ill, 1);      chk("ro_write_rdata", rd, 0);
    acc(RD, A_MHARTID, 0, 0, rd, ill);    chk("ro_unchanged", rd, 5);
    acc(RD, 12'h7C0, 0, 0, rd, ill);
    chk("unknown_illegal", ill, 1);       chk("unknown_rdata", rd, 0);
    acc(RS, A_MHARTID, 0, 0, rd, ill);
    chk("rs_x0_legal", ill, 0);           chk("rs_x0_rdata", rd, 5);
    acc(RW, A_MVENDORID, 1, 1, rd, ill);  chk("mvendorid_wr_illegal", ill, 1);
    acc(RW, A_MEPC, 1, 32'h1237, rd, ill);
    acc(RD, A_MEPC, 0, 0, rd, ill);       chk("mepc_mask", rd, 32'h1234);

    // reset mid-operation beats a trap in the same cycle
    acc(RW, A_MSCRATCH, 1, 32'hABCD, rd, ill);
    rst = 1; trap_enter = 1; trap_cause = 32'h5; trap_pc = 32'h444; step();
    chk("rst_over_trap_mepc", mepc_o, 0);
    rst = 0; trap_enter = 0;
    acc(RD, A_MSTATUS, 0, 0, rd, ill);    chk("rst2_mstatus", rd, 32'h1800);
    acc(RD, A_MSCRATCH, 0, 0, rd, ill);   chk("rst2_mscratch", rd, 0);
    acc(RD, A_MTVEC, 0, 0, rd, ill);      chk("rst2_mtvec", rd, 32'h100);
    acc(RD, A_MCAUSE, 0, 0, rd, ill);     chk("rst2_mcause", rd, 0);
    acc(RD, A_MCINH, 0, 0, rd, ill);      chk("rst2_mcinh", rd, 0);
    instret_inc = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
